logic_fold_unit: RTL and testbench
==================================

# logic_fold_unit

Parametrised, registered bitwise logic unit: the sequential successor to the gate-level AND/OR/XOR primitives. It applies one of eight selectable N-bit bitwise operations per beat. It runs either one-shot on two operands, or as a fold that accumulates a stream of operands into one result. Input and output use valid/ready handshakes, so it can sit between the register file and writeback or behind a streaming source.

## Interface
- WIDTH, 16: operand/result width in bits (≥1).
- CNT_W, 8: width of beat counter (≥1).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; ignored in fold mode.
- in_op  in  3  operation select.
- in_acc  in  1  0 = one-shot, 1 = fold beat.
- in_last  in  1  final beat of a fold packet; ignored when in_acc=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data == 0.
- out_count  out  CNT_W  beats contributing to out_data, saturating.

## Operation
- Op encoding (x, y): 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS x, 7 NOT x.
- Beat accepted when in_valid && in_ready.
- One-shot (in_acc=0):
  - Result = op(in_a, in_b), loaded into the output register; out_count=1.
  - A one-shot beat is legal only in IDLE; in FOLD it is treated as a fold beat.
- Fold state machine, states IDLE and FOLD:
  - IDLE, fold beat, !in_last: acc ← in_a, cnt ← 1 → FOLD. No output.
  - IDLE, fold beat, in_last: output in_a, count 1, stay IDLE.
  - FOLD, beat, !in_last: acc ← op(acc, in_a), cnt ← sat(cnt+1).
  - FOLD, beat, in_last: output op(acc, in_a), count sat(cnt+1) → IDLE.
  - Op is taken per beat. The first beat's op is ignored.
- in_ready = !out_valid || out_ready, in all states (single output stage, full throughput).
- Output register holds out_data, out_zero and out_count stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a result-producing beat is accepted in the same cycle; that beat's result replaces it (back-to-back).
- Counter saturates at 2^CNT_W−1; never wraps.
- Reset values: out_valid=0, out_data=0, out_zero=1, out_count=0, state IDLE, acc=0, cnt=0.
- Reset mid-packet discards the partial fold. A pending output is dropped.

## Timing
- Latency: result visible on out_data one cycle after the accepting edge of the one-shot or last beat.
- No combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready only.
- rst has priority over every other event in the same cycle.

## Structure
- Shared package logic_pkg: op encoding constants (OP_AND … OP_NOT), state encoding (ST_IDLE, ST_FOLD).
- Sub-module logic_op_core: combinational WIDTH-wide op(x, y, op). Instantiated once, with x muxed between in_a (one-shot) and acc (fold).

## Test plan
- One-shot XOR, in_a=16'h00FF, in_b=16'h0F0F → next cycle out_data=16'h0FF0, out_zero=0, out_count=1. Sweep all 8 ops on a=16'hF0F0, b=16'hFF00: AND F000, OR FFF0, XOR 0FF0, NAND 0FFF, NOR 000F, XNOR F00F, PASS F0F0, NOT 0F0F.
- Fold AND: F0F0, FF00, F000(last) → a single out_data=16'hF000, out_count=3. No out_valid after beats 1–2.
- Single-beat fold, in_a=16'h1234 with in_last → out_data=16'h1234, count 1. XOR-fold 16'h00FF, 16'h00FF(last) → out_data 0, out_zero=1.
- Backpressure: out_ready=0 with a result pending → in_ready=0, second beat stalls, outputs stable 5 cycles. Raise out_ready with in_valid held → old result taken, new one presented the next cycle.
- CNT_W=2: 6-beat OR fold → out_count=3 (saturated).
- Assert rst after 2 beats of a fold → all outputs at reset values. A following single-beat fold of 16'hABCD yields 16'hABCD, count 1.

Source files
------------

// File: rtl/logic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pkg
//  Description : Shared op-select and fold-state encodings for logic_fold_unit.
//  Revision    : 1.0  initial release
// ============================================================================
package logic_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/logic_op_core.sv
`default_nettype none
// ============================================================================
//  Module      : logic_op_core
//  Description : Combinational WIDTH-bit bitwise operator selected by op.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_op_core
    import logic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_XOR:  res = x ^ y;
            OP_NAND: res = ~(x & y);
            OP_NOR:  res = ~(x | y);
            OP_XNOR: res = ~(x ^ y);
            OP_PASS: res = x;
            default: res = ~x;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_fold_unit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_fold_unit
//  Description : Registered bitwise logic unit, one-shot or stream fold,
//                with valid/ready handshakes and a single output stage.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_fold_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state, w_nxt_state;
    logic [WIDTH-1:0] r_acc, w_nxt_acc;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt, w_cnt_inc;
    logic             r_out_valid, w_nxt_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_zero;
    logic [CNT_W-1:0] r_out_count;

    logic             w_accept, w_produce, w_in_fold;
    logic [WIDTH-1:0] w_x, w_y, w_core, w_res;
    logic [CNT_W-1:0] w_res_cnt;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_in_fold = (r_state == ST_FOLD);
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    // One operator shared by both modes: fold combines acc with in_a.
    assign w_x = w_in_fold ? r_acc : in_a;
    assign w_y = w_in_fold ? in_a  : in_b;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .x   (w_x),
        .y   (w_y),
        .op  (in_op),
        .res (w_core)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_acc   = r_acc;
        w_nxt_cnt   = r_cnt;
        w_produce   = 1'b0;
        w_res       = '0;
        w_res_cnt   = '0;
        if (w_accept) begin
            if (w_in_fold) begin
                // Any beat mid-packet is a fold beat, whatever in_acc says.
                w_nxt_acc = w_core;
                w_nxt_cnt = w_cnt_inc;
                if (in_last) begin
                    w_produce   = 1'b1;
                    w_res       = w_core;
                    w_res_cnt   = w_cnt_inc;
                    w_nxt_state = ST_IDLE;
                end
            end else if (!in_acc) begin
                w_produce = 1'b1;
                w_res     = w_core;
                w_res_cnt = c_cnt_one;
            end else if (in_last) begin
                w_produce = 1'b1;
                w_res     = in_a;
                w_res_cnt = c_cnt_one;
            end else begin
                w_nxt_acc   = in_a;
                w_nxt_cnt   = c_cnt_one;
                w_nxt_state = ST_FOLD;
            end
        end
        w_nxt_valid = w_produce ? 1'b1 : (out_ready ? 1'b0 : r_out_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b1;
            r_out_count <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_acc       <= w_nxt_acc;
            r_cnt       <= w_nxt_cnt;
            r_out_valid <= w_nxt_valid;
            if (w_produce) begin
                r_out_data  <= w_res;
                r_out_zero  <= (w_res == '0);
                r_out_count <= w_res_cnt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_fold_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_fold_unit
//  Description : Randomised and directed bench for logic_fold_unit against a
//                packet-level reference model (16-bit; counters 8 and 2 bits).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_logic_fold_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_acc, in_last, out_ready;
    logic [15:0] in_a, in_b;
    logic [2:0]  in_op;
    wire         in_ready, out_valid, out_zero;
    wire  [15:0] out_data;
    wire  [7:0]  out_count;
    wire         in_ready2, out_valid2, out_zero2;
    wire  [15:0] out_data2;
    wire  [1:0]  out_count2;

    always #5 clk = ~clk;

    logic_fold_unit #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_count(out_count)
    );

    logic_fold_unit #(.WIDTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_zero(out_zero2), .out_count(out_count2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                           input logic [2:0] op);
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    // Reference model: buffer the whole packet, reduce it when it ends.
    typedef struct { logic [15:0] a; logic [2:0] op; } beat_t;
    beat_t       pkt[$];
    logic [15:0] m_data;
    int          m_n;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic acc, input logic last);
        bit    got;
        bit    produced;
        beat_t bt;
        in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
        in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept", {31'd0, got}, 32'd1);
        produced = 1'b0;
        if (pkt.size() == 0 && !acc) begin
            m_data = ref_op(a, b, op);
            m_n = 1;
            produced = 1'b1;
        end else begin
            bt.a = a; bt.op = op;
            pkt.push_back(bt);
            if (last) begin
                m_data = pkt[0].a;
                for (int i = 1; i < pkt.size(); i++) m_data = ref_op(m_data, pkt[i].a, pkt[i].op);
                m_n = pkt.size();
                pkt.delete();
                produced = 1'b1;
            end
        end
        chk("valid", {31'd0, out_valid}, {31'd0, produced});
        if (produced) begin
            chk("data",   {16'd0, out_data},  {16'd0, m_data});
            chk("zero",   {31'd0, out_zero},  {31'd0, m_data == 16'd0});
            chk("count",  {24'd0, out_count}, (m_n > 255) ? 32'd255 : m_n);
            chk("data2",  {16'd0, out_data2}, {16'd0, m_data});
            chk("count2", {30'd0, out_count2}, (m_n > 3) ? 32'd3 : m_n);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"},  {16'd0, out_data},  32'd0);
        chk({tag, "_zero"},  {31'd0, out_zero},  32'd1);
        chk({tag, "_count"}, {24'd0, out_count}, 32'd0);
        chk({tag, "_count2"}, {30'd0, out_count2}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [15:0] sweep_exp [8];
    logic [15:0] held;

    initial begin
        sweep_exp[0] = 16'hF000; sweep_exp[1] = 16'hFFF0;
        sweep_exp[2] = 16'h0FF0; sweep_exp[3] = 16'h0FFF;
        sweep_exp[4] = 16'h000F; sweep_exp[5] = 16'hF00F;
        sweep_exp[6] = 16'hF0F0; sweep_exp[7] = 16'h0F0F;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        idle(3);
        check_reset_state("rst");
        rst = 1'b0;

        beat(16'h00FF, 16'h0F0F, 3'd2, 1'b0, 1'b0);
        chk("xor_dir", {16'd0, out_data}, 32'h0FF0);

        for (int i = 0; i < 8; i++) begin
            beat(16'hF0F0, 16'hFF00, 3'(i), 1'b0, 1'b0);
            chk("sweep", {16'd0, out_data}, {16'd0, sweep_exp[i]});
        end

        beat(16'hF0F0, 16'h0000, 3'd0, 1'b1, 1'b0);
        beat(16'hFF00, 16'h0000, 3'd0, 1'b1, 1'b0);
        beat(16'hF000, 16'h0000, 3'd0, 1'b1, 1'b1);
        chk("fold_and", {16'd0, out_data}, 32'hF000);
        chk("fold_cnt", {24'd0, out_count}, 32'd3);

        beat(16'h1234, 16'h0000, 3'd5, 1'b1, 1'b1);
        chk("single", {16'd0, out_data}, 32'h1234);
        beat(16'h00FF, 16'h0000, 3'd2, 1'b1, 1'b0);
        beat(16'h00FF, 16'h0000, 3'd2, 1'b1, 1'b1);
        chk("xor_zero", {31'd0, out_zero}, 32'd1);

        // Backpressure: first result held while a second beat waits.
        idle(1);
        chk("drain", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        beat(16'h1234, 16'h00FF, 3'd0, 1'b0, 1'b0);
        held = out_data;
        in_a = 16'h00F0; in_b = 16'h0F00; in_op = 3'd1; in_acc = 1'b0; in_last = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data",  {16'd0, out_data}, 32'h0034);
            chk("bp_count", {24'd0, out_count}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_data",  {16'd0, out_data}, 32'h0FF0);
        idle(1);

        for (int i = 0; i < 6; i++) beat(16'h0001 << i, 16'h0, 3'd1, 1'b1, i == 5);
        chk("sat_cnt2", {30'd0, out_count2}, 32'd3);
        chk("cnt6", {24'd0, out_count}, 32'd6);

        beat(16'h1111, 16'h0, 3'd1, 1'b1, 1'b0);
        beat(16'h2222, 16'h0, 3'd1, 1'b1, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        pkt.delete();
        check_reset_state("midrst");
        beat(16'hABCD, 16'h0, 3'd3, 1'b1, 1'b1);
        chk("post_rst", {16'd0, out_data}, 32'hABCD);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            beat(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
